entrada_antirrebote: RTL and testbench

- Two-channel input conditioning stage for Nexys A7 slide switches and push-buttons.
- Sits directly upstream of the 2-input logic-gate modules and drives their in_a / in_b inputs.
- Each raw asynchronous input is synchronised with two flops, then debounced by a stability counter.
- Per channel it produces a clean level plus one-cycle rise and fall pulses.

---
 rtl/entrada_antirrebote.sv | 115 +++++++++++
 tb/tb_entrada_antirrebote.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/entrada_antirrebote.sv
// Two-channel input conditioner: 2-flop synchroniser plus stability-counter
// debouncer per channel, with registered one-cycle rise/fall pulses.
module entrada_antirrebote #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic out_a,
    output logic out_b,
    output logic rise_a,
    output logic fall_a,
    output logic rise_b,
    output logic fall_b
);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } state_e;

    localparam int              NUM_CH   = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel 0 is A, channel 1 is B.
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] out_q,   out_d;
    logic [NUM_CH-1:0] rise_q,  rise_d;
    logic [NUM_CH-1:0] fall_q,  fall_d;
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];

    assign raw = {raw_b, raw_a};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        out_d   = out_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch]   = cnt_q[ch];
            state_d[ch] = state_q[ch];
            case (state_q[ch])
                ST_STABLE: begin
                    cnt_d[ch] = '0;
                    if (sync2_q[ch] != out_q[ch]) begin
                        cnt_d[ch]   = CNT_ONE;
                        state_d[ch] = ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (sync2_q[ch] == out_q[ch]) begin
                        // Bounced back before the input proved stable: drop the run.
                        cnt_d[ch]   = '0;
                        state_d[ch] = ST_STABLE;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        out_d[ch]   = sync2_q[ch];
                        rise_d[ch]  = sync2_q[ch];
                        fall_d[ch]  = ~sync2_q[ch];
                        cnt_d[ch]   = '0;
                        state_d[ch] = ST_STABLE;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[ch]   = '0;
                    state_d[ch] = ST_STABLE;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is async and clears the whole pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]   <= '0;
                state_q[ch] <= ST_STABLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]   <= cnt_d[ch];
                state_q[ch] <= state_d[ch];
            end
        end
    end

    assign out_a  = out_q[0];
    assign out_b  = out_q[1];
    assign rise_a = rise_q[0];
    assign fall_a = fall_q[0];
    assign rise_b = rise_q[1];
    assign fall_b = fall_q[1];

endmodule

// File: tb/tb_entrada_antirrebote.sv
// Bench for entrada_antirrebote: directed plan plus random toggling, compared
// every cycle against a run-length reference model of the debouncer.
module tb_entrada_antirrebote;

    localparam int S = 8;

    logic clk = 1'b0;
    logic rst_n, raw_a, raw_b;
    logic out_a, out_b, rise_a, fall_a, rise_b, fall_b;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    int rise_cnt_a  = 0;
    int fall_cnt_a  = 0;

    // Reference model: synchroniser delay, then the edge at which the current
    // unbroken run of "sample differs from output" began.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_o  [2];
    logic m_r  [2];
    logic m_f  [2];
    int   m_start [2];

    entrada_antirrebote #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .raw_a(raw_a), .raw_b(raw_b),
        .out_a(out_a), .out_b(out_b), .rise_a(rise_a), .fall_a(fall_a),
        .rise_b(rise_b), .fall_b(fall_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_o[ch] = 1'b0;
            m_r[ch]  = 1'b0; m_f[ch]  = 1'b0; m_start[ch] = -1;
        end
    endtask

    task automatic model_edge();
        logic s, r;
        for (int ch = 0; ch < 2; ch++) begin
            r = (ch == 0) ? raw_a : raw_b;
            s = m_s2[ch];
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = r;
            m_r[ch] = 1'b0;
            m_f[ch] = 1'b0;
            if (s !== m_o[ch]) begin
                if (m_start[ch] < 0) m_start[ch] = edge_n;
                if (edge_n - m_start[ch] + 1 == S) begin
                    m_o[ch] = s;
                    m_r[ch] = s;
                    m_f[ch] = ~s;
                    m_start[ch] = -1;
                end
            end else begin
                m_start[ch] = -1;
            end
        end
    endtask

    task automatic check_all();
        check("out_a",  out_a,  m_o[0]);
        check("out_b",  out_b,  m_o[1]);
        check("rise_a", rise_a, m_r[0]);
        check("fall_a", fall_a, m_f[0]);
        check("rise_b", rise_b, m_r[1]);
        check("fall_b", fall_b, m_f[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (rst_n) model_edge();
        else model_reset();
        #1;
        if (rise_a === 1'b1) rise_cnt_a++;
        if (fall_a === 1'b1) fall_cnt_a++;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edges from the next one (edge 1) until out_a reaches val; 30 means timeout.
    task automatic wait_out_a(input logic val, output int n);
        n = 0;
        while (out_a !== val && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, r0, f0;
        // 1. reset with both raws high, then release
        rst_n = 1'b0; raw_a = 1'b1; raw_b = 1'b1;
        #2;
        model_reset();
        check_all();
        ticks(2);
        rst_n = 1'b1;
        wait_out_a(1'b1, n);
        check_int("reset_release_latency", n, S + 2);
        check("reset_release_rise_a", rise_a, 1'b1);
        check("reset_release_out_b", out_b, 1'b1);
        tick();

        // 2. clean press on A
        raw_a = 1'b0;
        ticks(S + 4);
        raw_a = 1'b1;
        r0 = rise_cnt_a;
        wait_out_a(1'b1, n);
        check_int("press_latency", n, S + 2);
        ticks(3);
        check_int("press_rise_count", rise_cnt_a - r0, 1);

        // 3. bounce, ending low, then settle high
        raw_a = 1'b0;
        ticks(S + 4);
        r0 = rise_cnt_a;
        for (int i = 0; i < 40; i++) begin
            raw_a = ((i / 3) % 2 == 0);
            tick();
        end
        check_int("bounce_no_pulse", rise_cnt_a - r0, 0);
        raw_a = 1'b1;
        wait_out_a(1'b1, n);
        check_int("bounce_settle_latency", n, S + 2);
        ticks(3);
        check_int("bounce_rise_count", rise_cnt_a - r0, 1);

        // 4. glitch of S-1 sampled cycles is rejected, then a real release
        f0 = fall_cnt_a;
        raw_a = 1'b0;
        ticks(S - 1);
        raw_a = 1'b1;
        ticks(S + 6);
        check("glitch_out_a_held", out_a, 1'b1);
        check_int("glitch_no_fall", fall_cnt_a - f0, 0);
        raw_a = 1'b0;
        wait_out_a(1'b0, n);
        check_int("release_latency", n, S + 2);
        ticks(3);
        check_int("release_fall_count", fall_cnt_a - f0, 1);

        // 5. simultaneous A rise and B fall
        raw_a = 1'b1; raw_b = 1'b0;
        wait_out_a(1'b1, n);
        check_int("simul_latency", n, S + 2);
        check("simul_rise_a", rise_a, 1'b1);
        check("simul_fall_b", fall_b, 1'b1);
        check("simul_out_b", out_b, 1'b0);
        ticks(2);

        // 6. async reset mid-count with out_a high
        f0 = fall_cnt_a;
        raw_a = 1'b0;
        ticks(7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_rst_out_a", out_a, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        ticks(S + 4);
        check_int("async_rst_no_fall", fall_cnt_a - f0, 0);

        // Random toggling on both channels, compared every cycle
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5, 0) == 0) raw_a = ~raw_a;
            if ($urandom_range(7, 0) == 0) raw_b = ~raw_b;
            if ($urandom_range(99, 0) < 3) begin
                for (int k = 0; k < 12; k++) tick();
            end else begin
                tick();
            end
        end
        ticks(S + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
